// File: rtl/ifu_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
// The HALT state only exists when IFU_MISALIGN_CHECK_EN is defined.
package ifu_pkg;

  localparam int ILEN = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } ifu_state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH
  } ifu_state_t;
`endif

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic            fault;
  } fetch_entry_t;

  // A faulting fetch never exposes the bus data to the decoder.
  function automatic fetch_entry_t make_entry(input logic [ILEN-1:0] data, input logic err);
    fetch_entry_t e;
    e.inst  = err ? '0 : data;
    e.fault = err;
    return e;
  endfunction

endpackage

// File: rtl/ifu_entry_buf.sv
// Fetch entry ring buffer: slots are allocated at request time and filled in
// response order, so program order is preserved without any reordering logic.
module ifu_entry_buf
  import ifu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inject,
  input  logic [XLEN-1:0] inject_pc,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [ILEN-1:0] fill_data,
  input  logic            fill_err,
  input  logic            pop_en,
  output logic            full,
  output logic            empty,
  output logic [PW-1:0]   outstanding,
  output logic            head_filled,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_inst,
  output logic            head_fault
);

  logic [PW-1:0]    alloc_q, fill_q, read_q;
  logic [PW-2:0]    alloc_idx, fill_idx, read_idx;
  logic [XLEN-1:0]  pc_q [DEPTH];
  fetch_entry_t     entry_q [DEPTH];
  logic [DEPTH-1:0] filled_q;

  assign alloc_idx   = alloc_q[PW-2:0];
  assign fill_idx    = fill_q[PW-2:0];
  assign read_idx    = read_q[PW-2:0];

  assign outstanding = alloc_q - fill_q;
  assign empty       = (alloc_q == read_q);
  assign full        = ((alloc_q - read_q) == PW'(DEPTH));

  assign head_filled = filled_q[read_idx];
  assign head_pc     = pc_q[read_idx];
  assign head_inst   = entry_q[read_idx].inst;
  assign head_fault  = entry_q[read_idx].fault;

  // An injected entry occupies slot 0 already filled, with nothing left to fetch for it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      read_q   <= '0;
      filled_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        entry_q[i] <= '0;
      end
    end else if (flush) begin
      alloc_q  <= inject ? PW'(1) : '0;
      fill_q   <= inject ? PW'(1) : '0;
      read_q   <= '0;
      filled_q <= inject ? DEPTH'(1) : '0;
      if (inject) begin
        pc_q[0]    <= inject_pc;
        entry_q[0] <= make_entry('0, 1'b1);
      end
    end else begin
      if (alloc_en) begin
        pc_q[alloc_idx]     <= alloc_pc;
        filled_q[alloc_idx] <= 1'b0;
        alloc_q             <= alloc_q + PW'(1);
      end
      if (fill_en) begin
        entry_q[fill_idx]  <= make_entry(fill_data, fill_err);
        filled_q[fill_idx] <= 1'b1;
        fill_q             <= fill_q + PW'(1);
      end
      if (pop_en) begin
        read_q <= read_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching instruction fetch unit: sequential fetches, in-order delivery to the
// IDU, and redirect flushing. Define IFU_MISALIGN_CHECK_EN to fault misaligned redirects.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            rsp_valid,
  input  logic [ILEN-1:0] rsp_data,
  input  logic            rsp_err,
  output logic            valid_out_idu,
  input  logic            ready_in_idu,
  output logic [XLEN-1:0] pc_out,
  output logic [ILEN-1:0] inst_out,
  output logic            fault_out
);

  localparam int PW = $clog2(DEPTH) + 1;

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   drop_q, drop_d;
  logic [XLEN-1:0] target_pc;
  logic            inject;
  logic            buf_full, buf_empty, head_filled;
  logic [PW-1:0]   buf_outstanding;
  logic            req_fire, dropping, fill_en, pop_en;

`ifdef IFU_MISALIGN_CHECK_EN
  assign target_pc = redirect_pc;
  assign inject    = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign target_pc = redirect_pc & ~XLEN'(3);
  assign inject    = 1'b0;
`endif

  // rst gates the request so nothing is offered to memory while reset is held.
  assign req_valid     = rst && (state_q == ST_RUN) && !redirect_valid && !buf_full;
  assign req_addr      = fetch_pc_q;
  assign req_fire      = req_valid && req_ready;

  assign dropping      = redirect_valid || (drop_q != '0);
  assign fill_en       = rsp_valid && !dropping && (buf_outstanding != '0);

  assign valid_out_idu = head_filled && !buf_empty && !redirect_valid;
  assign pop_en        = valid_out_idu && ready_in_idu;

  ifu_entry_buf #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_entry_buf (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .inject      (inject),
    .inject_pc   (target_pc),
    .alloc_en    (req_fire),
    .alloc_pc    (fetch_pc_q),
    .fill_en     (fill_en),
    .fill_data   (rsp_data),
    .fill_err    (rsp_err),
    .pop_en      (pop_en),
    .full        (buf_full),
    .empty       (buf_empty),
    .outstanding (buf_outstanding),
    .head_filled (head_filled),
    .head_pc     (pc_out),
    .head_inst   (inst_out),
    .head_fault  (fault_out)
  );

  // A response arriving with the redirect already answers one of the stale requests.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      drop_d     = drop_q + buf_outstanding
                 - PW'(rsp_valid && ((drop_q != '0) || (buf_outstanding != '0)));
      state_d    = (drop_d != '0) ? ST_FLUSH : ST_RUN;
`ifdef IFU_MISALIGN_CHECK_EN
      if (inject) begin
        state_d = ST_HALT;
      end
`endif
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - PW'(1);
      end
      if ((state_q == ST_FLUSH) && (drop_d == '0)) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed testbench for ifu_prefetch with a small in-order memory model and IDU log.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        valid_out_idu;
  logic        ready_in_idu = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        fault_out;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    int          cyc;
  } pop_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  pop_t        pop_log[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  mreq_t       mem_q[$];

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          rel_cyc = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] err_addr = '1;

  ifu_prefetch #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .valid_out_idu  (valid_out_idu),
    .ready_in_idu   (ready_in_idu),
    .pc_out         (pc_out),
    .inst_out       (inst_out),
    .fault_out      (fault_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: log handshakes, advance one clock, update memory.
  task automatic run_cycle();
    logic        fire;
    logic [31:0] fa;
    pop_t        p;
    mreq_t       m;
    #1;
    fire = req_valid && req_ready;
    fa   = req_addr;
    if (fire) begin
      req_log.push_back(fa);
      req_cyc.push_back(cyc);
    end
    if (valid_out_idu && ready_in_idu) begin
      p.pc = pc_out; p.inst = inst_out; p.fault = fault_out; p.cyc = cyc;
      pop_log.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!rst) begin
      mem_q.delete();
    end else if (fire) begin
      m.addr = fa; m.due = cyc;
      mem_q.push_back(m);
    end
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if (rst && !mem_hold && (mem_q.size() > 0) && (mem_q[0].due <= cyc)) begin
      m         = mem_q.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = mem_word(m.addr);
      rsp_err   = (m.addr == err_addr);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    req_ready = 1'b0;
    ready_in_idu = 1'b0;
    mem_hold = 1'b0;
    err_addr = '1;
    run_cycles(2);
    pop_log.delete();
    req_log.delete();
    req_cyc.delete();
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid", req_valid, 0);
    checkOutput("rst_req_addr", req_addr, 32'h8000_0000);
    checkOutput("rst_valid_out", valid_out_idu, 0);
    checkOutput("rst_pc_out", pc_out, 0);
    checkOutput("rst_inst_out", inst_out, 0);
    checkOutput("rst_fault_out", fault_out, 0);

    // Streaming: one instruction per cycle.
    do_reset();
    req_ready = 1'b1;
    ready_in_idu = 1'b1;
    #1;
    checkOutput("first_req_valid", req_valid, 1);
    checkOutput("first_req_addr", req_addr, 32'h8000_0000);
    run_cycles(6);
    checkOutput("stream_pops", pop_log.size(), 4);
    checkOutput("stream_pc0", pop_log[0].pc, 32'h8000_0000);
    checkOutput("stream_pc1", pop_log[1].pc, 32'h8000_0004);
    checkOutput("stream_pc2", pop_log[2].pc, 32'h8000_0008);
    checkOutput("stream_inst0", pop_log[0].inst, 32'h9357_9BDF);
    checkOutput("stream_inst1", pop_log[1].inst, 32'h9357_9BDB);
    checkOutput("stream_fault0", pop_log[0].fault, 0);
    checkOutput("stream_latency", pop_log[0].cyc - req_cyc[0], 2);
    checkOutput("stream_b2b_1", pop_log[1].cyc - pop_log[0].cyc, 1);
    checkOutput("stream_b2b_2", pop_log[2].cyc - pop_log[1].cyc, 1);

    // Full buffer with a stalled IDU, then a single pop.
    do_reset();
    req_ready = 1'b1;
    run_cycles(8);
    checkOutput("full_req_count", req_log.size(), 4);
    checkOutput("full_last_addr", req_log[3], 32'h8000_000C);
    checkOutput("full_req_valid", req_valid, 0);
    checkOutput("full_head_valid", valid_out_idu, 1);
    checkOutput("full_head_pc", pc_out, 32'h8000_0000);
    req_log.delete();
    ready_in_idu = 1'b1;
    run_cycle();
    ready_in_idu = 1'b0;
    run_cycles(4);
    checkOutput("pop_one_req_count", req_log.size(), 1);
    checkOutput("pop_one_req_addr", req_log[0], 32'h8000_0010);
    checkOutput("pop_one_pops", pop_log.size(), 1);

    // Redirect with three fetches outstanding.
    do_reset();
    mem_hold = 1'b1;
    req_ready = 1'b1;
    ready_in_idu = 1'b1;
    run_cycles(3);
    checkOutput("flush_outstanding", req_log.size(), 3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0100;
    run_cycle();
    redirect_valid = 1'b0;
    req_log.delete();
    req_cyc.delete();
    pop_log.delete();
    run_cycles(2);
    checkOutput("flush_no_req", req_log.size(), 0);
    mem_hold = 1'b0;
    rel_cyc = cyc;
    run_cycles(8);
    checkOutput("flush_new_addr", req_log[0], 32'h8000_0100);
    checkOutput("flush_next_addr", req_log[1], 32'h8000_0104);
    checkOutput("flush_restart_cyc", req_cyc[0] - rel_cyc, 4);
    checkOutput("flush_first_pc", pop_log[0].pc, 32'h8000_0100);
    checkOutput("flush_first_inst", pop_log[0].inst, 32'h9357_9ADF);

    // Access fault on one fetch, fetching continues.
    do_reset();
    err_addr = 32'h8000_0008;
    req_ready = 1'b1;
    ready_in_idu = 1'b1;
    run_cycles(8);
    checkOutput("err_pc", pop_log[2].pc, 32'h8000_0008);
    checkOutput("err_fault", pop_log[2].fault, 1);
    checkOutput("err_inst", pop_log[2].inst, 0);
    checkOutput("after_err_pc", pop_log[3].pc, 32'h8000_000C);
    checkOutput("after_err_fault", pop_log[3].fault, 0);
    checkOutput("after_err_inst", pop_log[3].inst, 32'h9357_9BD3);
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid_out", valid_out_idu, 0);
    checkOutput("midrst_req_valid", req_valid, 0);
    checkOutput("midrst_req_addr", req_addr, 32'h8000_0000);

    // Redirect coinciding with the only outstanding response.
    do_reset();
    req_ready = 1'b1;
    ready_in_idu = 1'b1;
    run_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    pop_log.delete();
    run_cycle();
    redirect_valid = 1'b0;
    #1;
    checkOutput("same_cyc_req_valid", req_valid, 1);
    checkOutput("same_cyc_req_addr", req_addr, 32'h8000_0200);
    run_cycles(4);
    checkOutput("same_cyc_first_pc", pop_log[0].pc, 32'h8000_0200);

`ifdef IFU_MISALIGN_CHECK_EN
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    run_cycle();
    redirect_valid = 1'b0;
    #1;
    checkOutput("mis_valid_out", valid_out_idu, 1);
    checkOutput("mis_pc_out", pc_out, 32'h8000_0102);
    checkOutput("mis_fault_out", fault_out, 1);
    checkOutput("mis_inst_out", inst_out, 0);
    checkOutput("mis_req_valid", req_valid, 0);
    req_ready = 1'b1;
    ready_in_idu = 1'b1;
    run_cycles(3);
    checkOutput("halt_no_req", req_log.size(), 0);
    checkOutput("halt_pops", pop_log.size(), 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0200;
    run_cycle();
    redirect_valid = 1'b0;
    #1;
    checkOutput("halt_exit_req_valid", req_valid, 1);
    checkOutput("halt_exit_req_addr", req_addr, 32'h8000_0200);
`else
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0102;
    run_cycle();
    redirect_valid = 1'b0;
    #1;
    checkOutput("align_req_valid", req_valid, 1);
    checkOutput("align_req_addr", req_addr, 32'h8000_0100);
    checkOutput("align_valid_out", valid_out_idu, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised prefetching instruction fetch unit between the PC/redirect logic and the IDU. Issues sequential fetch requests to instruction memory over a valid/ready channel, keeps up to DEPTH fetches in flight or buffered, and presents the results to the IDU in program order over a valid/ready handshake. A redirect flushes buffered and in-flight fetches without stalling the memory channel protocol.

## Interface
- XLEN, 32, address/PC width (≥ 32)
- DEPTH, 4, entry buffer depth = max in-flight + buffered fetches (power of 2, ≥ 2)
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch address
- req_valid  out  1  fetch request to memory
- req_ready  in  1  memory accepts request
- req_addr  out  XLEN  fetch address
- rsp_valid  in  1  fetch response, in request order, no back-pressure
- rsp_data  in  32  instruction word
- rsp_err  in  1  access fault for this response
- valid_out_idu  out  1  head entry ready for IDU
- ready_in_idu  in  1  IDU accepts head entry
- pc_out  out  XLEN  PC of head entry
- inst_out  out  32  instruction of head entry
- fault_out  out  1  head entry carries a fault

## Operation
- States: RUN, FLUSH, HALT (HALT exists only with IFU_MISALIGN_CHECK_EN). Reset → RUN, fetch_pc = RESET_PC.
- Entry buffer: DEPTH slots {pc, inst, fault, filled}; pointers alloc, fill, read, each $clog2(DEPTH)+1 bits with wrap bit.
- req_valid = (state == RUN) && !redirect_valid && (alloc − read < DEPTH); req_addr = fetch_pc.
- Request handshake: slot[alloc].pc ← fetch_pc, filled ← 0; alloc++, fetch_pc += 4 (wraps mod 2^XLEN).
- Response (fill ≠ alloc, not being dropped): slot[fill] ← {rsp_data, rsp_err}, filled ← 1; fill++. On rsp_err, inst stored as 0. Fetching continues after faults.
- rsp_valid with no outstanding request and drop_cnt == 0: protocol violation, ignored.
- valid_out_idu = slot[read].filled && (read ≠ alloc) && !redirect_valid; handshake → read++.
- Redirect: alloc, fill, read ← 0; all filled ← 0; fetch_pc ← redirect_pc; drop_cnt ← outstanding (alloc − fill) minus 1 if rsp_valid this cycle. drop_cnt ≠ 0 → FLUSH, else RUN.
- FLUSH: no requests; each rsp_valid decrements drop_cnt, data discarded; at 0 → RUN. Redirect in FLUSH: fetch_pc replaced, drop_cnt continues counting down (response that cycle still decrements).
- Full buffer: req_valid low until an IDU pop. Simultaneous request, response and pop in one cycle all take effect.

## Timing
- Reset values: req_valid 0 while rst low, req_addr = RESET_PC, valid_out_idu 0, pc_out/inst_out/fault_out 0.
- First request visible the first cycle after reset release.
- Response in cycle M for head slot → valid_out_idu in M+1 (registered fill, no bypass).
- Redirect in cycle N with nothing outstanding → req_valid with req_addr = redirect_pc in N+1.
- Redirect with k outstanding → first new request in the cycle after the k-th stale response.
- Back-to-back: with req_ready=1 and single-cycle memory, sustained one instruction per cycle.
- Reset asserted mid-operation: all state cleared immediately; stale responses after reset are ignored (memory is reset with the same rst).

## Configuration
- IFU_MISALIGN_CHECK_EN defined: redirect_pc[1:0] ≠ 0 → no request issued; one slot allocated with pc = redirect_pc, inst 0, fault 1, filled 1; state → HALT (drops still counted), HALT exits only on next redirect.
- Not defined: redirect_pc[1:0] forced to 0, no fault, no HALT state.

## Structure
- Package ifu_pkg: state enum ifu_state_t, ILEN = 32, default RESET_PC constant, fetch entry struct typedef.
- Sub-module ifu_entry_buf: DEPTH-slot storage with alloc/fill/read pointers, full/empty/outstanding outputs; FSM, fetch_pc and drop counter stay in ifu_prefetch.

## Test plan
- Reset release, req_ready=1, 1-cycle memory, ready_in_idu=1 → pc_out 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, fault_out 0.
- ready_in_idu=0, DEPTH=4 → exactly 4 handshakes, then req_valid low; one pop → exactly one further request at 8000_0010.
- 3 outstanding, redirect to 8000_0100 → FLUSH, 3 responses discarded, next req_addr 8000_0100, first IDU pc 8000_0100.
- Response with rsp_err=1 at 8000_0008 → that entry fault_out 1, inst_out 0; next entry 8000_000C fault_out 0.
- Redirect and rsp_valid same cycle with 1 outstanding → drop_cnt 0, request at redirect_pc next cycle.
- With IFU_MISALIGN_CHECK_EN, redirect to 8000_0102 → single entry pc 8000_0102, fault_out 1, no req_valid until redirect to 8000_0200.
